// File: rtl/cache_dm.sv
// cache_dm: direct-mapped, write-through, no-write-allocate cache in front of
// one AXI3 port. It uses the same command/ready/error interface as the
// uncached path. The cache keeps a registered tag/valid snapshot and word
// storage for each line. Read misses fill a whole line with one INCR burst.
// Writes always go out as single-beat AXI writes.
// Optional: define CACHE_DM_STATS_EN to add saturating read hit/miss counters.
module cache_dm #(
    parameter int unsigned LINES          = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned BIT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2:0]           command,
    output logic                 ready,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    output logic [31:0]          rdata,
    output logic [1:0]           error,
    output logic                 mem_awvalid,
    input  logic                 mem_awready,
    output logic [31:0]          mem_awaddr,
    output logic [7:0]           mem_awlen,
    output logic [2:0]           mem_awsize,
    output logic [1:0]           mem_awburst,
    output logic                 mem_wvalid,
    input  logic                 mem_wready,
    output logic [BIT_WIDTH-1:0] mem_wdata,
    output logic [3:0]           mem_wstrb,
    output logic                 mem_wlast,
    input  logic                 mem_bvalid,
    input  logic [1:0]           mem_bresp,
    output logic                 mem_bready,
    output logic                 mem_arvalid,
    input  logic                 mem_arready,
    output logic [31:0]          mem_araddr,
    output logic [7:0]           mem_arlen,
    output logic [2:0]           mem_arsize,
    output logic [1:0]           mem_arburst,
    input  logic                 mem_rvalid,
    input  logic [BIT_WIDTH-1:0] mem_rdata,
    input  logic [1:0]           mem_rresp,
    input  logic                 mem_rlast,
    output logic                 mem_rready
`ifdef CACHE_DM_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
`endif
);

    localparam int unsigned OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int unsigned TAG_LSB  = OFF_BITS + IDX_BITS + 2;
    localparam int unsigned TAG_W    = 32 - TAG_LSB;
    localparam logic [31:0] LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FILL_AR, FILL_R, WR_ADDR_DATA, WR_RESP, INVAL
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_READ  = 3'd1,
        CMD_WRITE = 3'd2,
        CMD_INVAL = 3'd3
    } cmd_t;

    state_t              state;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic                wr_q;
    logic                valid_q;
    logic [TAG_W-1:0]    tag_q;
    logic                hit_q;
    logic                rerr;
    logic [OFF_W-1:0]    beat;
    logic [IDX_BITS-1:0] inv_idx;
    logic [LINES-1:0]    valid;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES][WORDS_PER_LINE];

    logic [OFF_W-1:0]    off;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] in_idx;
    logic [TAG_W-1:0]    tag;
    logic                accept;
    logic                hit;
    logic                fill_we;
    logic                tag_we;
    logic                hit_we;
    logic                rresp_bad;

    generate
        if (OFF_BITS > 0) begin : g_off
            assign off = addr_q[OFF_BITS+1:2];
        end else begin : g_no_off
            assign off = '0;
        end
    endgenerate

    assign idx    = addr_q[TAG_LSB-1 -: IDX_BITS];
    assign in_idx = addr[TAG_LSB-1 -: IDX_BITS];
    assign tag    = addr_q[31:TAG_LSB];

    assign mem_awlen   = 8'd0;
    assign mem_awsize  = 3'd2;
    assign mem_awburst = 2'b01;
    assign mem_wlast   = 1'b1;
    assign mem_arlen   = 8'(WORDS_PER_LINE - 1);
    assign mem_arsize  = 3'd2;
    assign mem_arburst = 2'b01;

    // Hit detection and storage write enables derived from the current state
    always_comb begin
        accept    = ready && (command != CMD_NONE);
        hit       = valid_q && (tag_q == tag);
        rresp_bad = (mem_rresp != 2'b00);
        fill_we   = (state == FILL_R) && mem_rvalid;
        tag_we    = fill_we && mem_rlast;
        hit_we    = (state == LOOKUP) && wr_q && hit;
    end

    // Tag and data storage: line fills plus byte-wise update on write hits
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[idx][beat] <= mem_rdata;
        end
        if (tag_we) begin
            tag_mem[idx] <= tag;
        end
        if (hit_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    data_mem[idx][off][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered core and AXI handshake outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ready       <= 1'b1;
            error       <= 2'd0;
            rdata       <= '0;
            valid       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_q        <= 1'b0;
            valid_q     <= 1'b0;
            tag_q       <= '0;
            hit_q       <= 1'b0;
            rerr        <= 1'b0;
            beat        <= '0;
            inv_idx     <= '0;
            mem_awvalid <= 1'b0;
            mem_awaddr  <= '0;
            mem_wvalid  <= 1'b0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            mem_bready  <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_araddr  <= '0;
            mem_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        error   <= 2'd0;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        wr_q    <= (command == CMD_WRITE);
                        tag_q   <= tag_mem[in_idx];
                        valid_q <= valid[in_idx];
                        case (command)
                            CMD_READ, CMD_WRITE: begin
                                ready <= 1'b0;
                                state <= LOOKUP;
                            end
                            CMD_INVAL: begin
                                ready   <= 1'b0;
                                inv_idx <= '0;
                                state   <= INVAL;
                            end
                            default: error <= 2'd3;
                        endcase
                    end
                end
                LOOKUP: begin
                    if (!wr_q) begin
                        if (hit) begin
                            rdata <= data_mem[idx][off];
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            mem_arvalid <= 1'b1;
                            mem_araddr  <= addr_q & ~LINE_MASK;
                            state       <= FILL_AR;
                        end
                    end else begin
                        hit_q       <= hit;
                        mem_awvalid <= 1'b1;
                        mem_wvalid  <= 1'b1;
                        mem_awaddr  <= addr_q & 32'hFFFF_FFFC;
                        mem_wdata   <= wdata_q;
                        mem_wstrb   <= wstrb_q;
                        state       <= WR_ADDR_DATA;
                    end
                end
                FILL_AR: begin
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        mem_rready  <= 1'b1;
                        beat        <= '0;
                        rerr        <= 1'b0;
                        state       <= FILL_R;
                    end
                end
                FILL_R: begin
                    if (mem_rvalid) begin
                        if (beat == off) begin
                            rdata <= mem_rdata;
                        end
                        beat <= beat + 1'b1;
                        rerr <= rerr | rresp_bad;
                        if (mem_rlast) begin
                            // The line becomes valid only if every beat returned OKAY
                            mem_rready  <= 1'b0;
                            valid[idx]  <= !(rerr || rresp_bad);
                            error       <= (rerr || rresp_bad) ? 2'd1 : 2'd0;
                            ready       <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W complete independently, in either order or together
                    if (mem_awready) begin
                        mem_awvalid <= 1'b0;
                    end
                    if (mem_wready) begin
                        mem_wvalid <= 1'b0;
                    end
                    if ((!mem_awvalid || mem_awready) && (!mem_wvalid || mem_wready)) begin
                        mem_bready <= 1'b1;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (mem_bvalid) begin
                        mem_bready <= 1'b0;
                        if (mem_bresp != 2'b00) begin
                            error <= 2'd2;
                            if (hit_q) begin
                                valid[idx] <= 1'b0;
                            end
                        end
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                INVAL: begin
                    valid[inv_idx] <= 1'b0;
                    inv_idx        <= inv_idx + 1'b1;
                    if (inv_idx == IDX_BITS'(LINES - 1)) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_DM_STATS_EN
    // Saturating read hit/miss counters, zeroed by reset or an invalidate command
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (accept && (command == CMD_INVAL)) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if ((state == LOOKUP) && !wr_q) begin
            if (hit) begin
                if (stat_hits != '1) begin
                    stat_hits <= stat_hits + 1'b1;
                end
            end else begin
                if (stat_misses != '1) begin
                    stat_misses <= stat_misses + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_dm.sv
// Self-checking bench for cache_dm. It contains an AXI slave with a sparse
// memory and a line-level reference model of cache contents.
module tb_cache_dm;

    localparam int unsigned LINES = 64;
    localparam int unsigned WPL   = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  command;
    logic        ready;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  error;
    logic        mem_awvalid, mem_awready;
    logic [31:0] mem_awaddr;
    logic [7:0]  mem_awlen;
    logic [2:0]  mem_awsize;
    logic [1:0]  mem_awburst;
    logic        mem_wvalid, mem_wready, mem_wlast;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_bvalid, mem_bready;
    logic [1:0]  mem_bresp;
    logic        mem_arvalid, mem_arready;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic        mem_rvalid, mem_rlast, mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;

    always #5 clk = ~clk;

    cache_dm #(.LINES(LINES), .WORDS_PER_LINE(WPL), .BIT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .command(command), .ready(ready), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .error(error),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
        .mem_awlen(mem_awlen), .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
        .mem_bvalid(mem_bvalid), .mem_bresp(mem_bresp), .mem_bready(mem_bready),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .mem_rlast(mem_rlast), .mem_rready(mem_rready)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          ar_count = 0, aw_count = 0, w_count = 0, r_beats = 0;
    int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_err_beat = -1;
    logic [1:0]  b_resp = 2'b00;
    logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [7:0]  last_arlen = '0;
    logic [3:0]  last_wstrb = '0;
    logic        saw_valid = 1'b0;

    logic [31:0] memory [logic [31:0]];
    logic        ref_valid [LINES];
    int unsigned ref_tag   [LINES];

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        if (!memory.exists(a)) memory[a] = $urandom;
        return memory[a];
    endfunction

    function automatic int unsigned line_idx(input logic [31:0] a);
        return (a / (4 * WPL)) % LINES;
    endfunction

    function automatic int unsigned line_tag(input logic [31:0] a);
        return a / (4 * WPL * LINES);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[line_idx(a)] && (ref_tag[line_idx(a)] == line_tag(a));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_arvalid || mem_awvalid || mem_wvalid) saw_valid = 1'b1;
    end

    // AR/R slave: one burst per accepted AR, error injected on a chosen beat
    initial begin : r_slave
        logic [31:0] a;
        logic [7:0]  len;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        mem_rresp = 2'b00; mem_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_arvalid) begin
                for (int d = 0; d < ar_delay; d++) @(negedge clk);
                mem_arready = 1'b1;
                a = mem_araddr; len = mem_arlen;
                last_araddr = a; last_arlen = len; ar_count++;
                @(negedge clk);
                mem_arready = 1'b0;
                for (int k = 0; k <= int'(len); k++) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_get(a + 32'(4 * k));
                    mem_rresp  = (k == r_err_beat) ? 2'b10 : 2'b00;
                    mem_rlast  = (k == int'(len));
                    while (!mem_rready) @(negedge clk);
                    @(negedge clk);
                    r_beats++;
                end
                mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
            end
        end
    end

    // AW/W/B slave: independent AW and W delays, then one B response
    initial begin : w_slave
        bit aw_done, w_done;
        int cnt;
        logic [31:0] tmp;
        mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (mem_awvalid || mem_wvalid) begin
                aw_done = 0; w_done = 0; cnt = 0;
                while (!(aw_done && w_done) && cnt < 100) begin
                    mem_awready = !aw_done && mem_awvalid && (cnt >= aw_delay);
                    mem_wready  = !w_done && mem_wvalid && (cnt >= w_delay);
                    if (mem_awready) last_awaddr = mem_awaddr;
                    if (mem_wready) begin
                        last_wdata = mem_wdata; last_wstrb = mem_wstrb;
                    end
                    @(negedge clk);
                    if (mem_awready) begin aw_done = 1; aw_count++; end
                    if (mem_wready)  begin w_done = 1;  w_count++;  end
                    mem_awready = 1'b0; mem_wready = 1'b0;
                    cnt++;
                end
                if (b_resp == 2'b00) begin
                    tmp = mem_get(last_awaddr);
                    for (int b = 0; b < 4; b++)
                        if (last_wstrb[b]) tmp[8*b +: 8] = last_wdata[8*b +: 8];
                    memory[last_awaddr] = tmp;
                end
                mem_bvalid = 1'b1; mem_bresp = b_resp;
                while (!mem_bready) @(negedge clk);
                @(negedge clk);
                mem_bvalid = 1'b0; mem_bresp = 2'b00;
            end
        end
    end

    task automatic do_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output int cyc);
        @(negedge clk);
        command = cmd; addr = a; wdata = wd; wstrb = ws;
        @(negedge clk);
        command = 3'd0;
        cyc = 1;
        while (!ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_within_budget", {31'd0, ready}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input string tag);
        int cyc;
        int ar0 = ar_count;
        bit exp_hit = ref_hit(a);
        logic [31:0] exp = mem_get(a & 32'hFFFF_FFFC);
        do_op(3'd1, a, $urandom, 4'($urandom), cyc);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_error"}, {30'd0, error}, 32'd0);
        if (exp_hit) begin
            check({tag, "_hit_no_ar"}, 32'(ar_count - ar0), 32'd0);
            check({tag, "_hit_latency"}, 32'(cyc), 32'd2);
        end else begin
            check({tag, "_miss_one_ar"}, 32'(ar_count - ar0), 32'd1);
            check({tag, "_araddr"}, last_araddr, a & ~32'(4 * WPL - 1));
        end
        ref_valid[line_idx(a)] = 1'b1;
        ref_tag[line_idx(a)]   = line_tag(a);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [1:0] resp, input string tag);
        int cyc;
        int aw0 = aw_count;
        int w0 = w_count;
        int ar0 = ar_count;
        bit exp_hit = ref_hit(a);
        b_resp = resp;
        do_op(3'd2, a, wd, ws, cyc);
        check({tag, "_one_aw"}, 32'(aw_count - aw0), 32'd1);
        check({tag, "_one_w"}, 32'(w_count - w0), 32'd1);
        check({tag, "_no_ar"}, 32'(ar_count - ar0), 32'd0);
        check({tag, "_awaddr"}, last_awaddr, a & 32'hFFFF_FFFC);
        check({tag, "_wdata"}, last_wdata, wd);
        check({tag, "_wstrb"}, {28'd0, last_wstrb}, {28'd0, ws});
        check({tag, "_error"}, {30'd0, error}, (resp != 2'b00) ? 32'd2 : 32'd0);
        if (resp != 2'b00 && exp_hit) ref_valid[line_idx(a)] = 1'b0;
        b_resp = 2'b00;
    endtask

    task automatic do_inval(input string tag);
        int cyc;
        do_op(3'd3, 32'd0, 32'd0, 4'd0, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(LINES + 1));
        for (int i = 0; i < int'(LINES); i++) ref_valid[i] = 1'b0;
    endtask

    initial begin : stimulus
        int cyc, ar0, aw0, beats0;
        logic [31:0] old, a, hold;
        for (int i = 0; i < int'(LINES); i++) begin ref_valid[i] = 1'b0; ref_tag[i] = 0; end
        memory[32'h1000] = 32'hDEADBEEF;
        rstn = 1'b0; command = 3'd0; addr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_error", {30'd0, error}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_axi_valids", {27'd0, mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready}, 32'd0);
        check("const_awlen_awsize_awburst", {19'd0, mem_awlen, mem_awsize, mem_awburst}, {19'd0, 8'd0, 3'd2, 2'b01});
        check("const_arlen_arsize_arburst", {19'd0, mem_arlen, mem_arsize, mem_arburst}, {19'd0, 8'(WPL - 1), 3'd2, 2'b01});
        check("const_wlast", {31'd0, mem_wlast}, 32'd1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // First read misses and fills the line; arlen is checked at the AR handshake
        do_read(32'h1000, "rd_1000_miss");
        check("rd_1000_arlen", {24'd0, last_arlen}, 32'(WPL - 1));
        check("rd_1000_value", rdata, 32'hDEADBEEF);
        do_read(32'h1004, "rd_1004_hit");

        // Write hit with low-half strobes, then read back merged word
        old = mem_get(32'h1004);
        hold = old;
        do_write(32'h1004, 32'h11223344, 4'b0011, 2'b00, "wr_1004");
        check("wr_rdata_holds", rdata, hold);
        do_read(32'h1004, "rd_1004_after_wr");
        check("rd_1004_merged", rdata, {old[31:16], 16'h3344});

        // Read with SLVERR on beat 2: all beats drained, line left invalid
        r_err_beat = 2; ar0 = ar_count; beats0 = r_beats;
        do_op(3'd1, 32'h2000, 32'd0, 4'd0, cyc);
        check("rderr_error", {30'd0, error}, 32'd1);
        check("rderr_one_ar", 32'(ar_count - ar0), 32'd1);
        check("rderr_beats", 32'(r_beats - beats0), 32'(WPL));
        ref_valid[line_idx(32'h2000)] = 1'b0;
        r_err_beat = -1;
        do_read(32'h2000, "rd_2000_refetch");

        // Delayed awready after wready with DECERR: one transaction, line invalidated
        aw_delay = 3; w_delay = 0;
        do_write(32'h1008, 32'hCAFEF00D, 4'b1111, 2'b11, "wr_decerr");
        aw_delay = 0;
        do_read(32'h1000, "rd_1000_after_werr");

        // Invalidate all, then the same line misses again
        do_inval("inval");
        do_read(32'h1000, "rd_1000_after_inval");

        // Illegal command: immediate error, no AXI activity, error persists
        ar0 = ar_count; aw0 = aw_count; hold = rdata;
        saw_valid = 1'b0;
        do_op(3'd5, 32'h1000, 32'd0, 4'd0, cyc);
        check("illegal_latency", 32'(cyc), 32'd1);
        check("illegal_error", {30'd0, error}, 32'd3);
        repeat (4) @(negedge clk);
        check("illegal_error_holds", {30'd0, error}, 32'd3);
        check("illegal_no_axi", {31'd0, saw_valid}, 32'd0);
        check("illegal_no_txn", 32'((ar_count - ar0) + (aw_count - aw0)), 32'd0);
        check("illegal_rdata_holds", rdata, hold);

        // Randomized mix over a few aliased lines
        for (int n = 0; n < 120; n++) begin
            a = 32'h0001_0000 + 32'($urandom_range(0, 2) * 32'h400)
                + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 3) * 4);
            ar_delay = $urandom_range(0, 2);
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            case ($urandom_range(0, 19))
                0: do_inval("rnd_inval");
                1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11: do_read(a, "rnd_rd");
                default: do_write(a, $urandom, 4'($urandom),
                                  ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00, "rnd_wr");
            endcase
        end
        ar_delay = 0; aw_delay = 0; w_delay = 0;

        // Reset during a line fill abandons it
        ar_delay = 30;
        @(negedge clk);
        command = 3'd1; addr = 32'h3000;
        @(negedge clk);
        command = 3'd0;
        repeat (3) @(negedge clk);
        check("midrst_arvalid_before", {31'd0, mem_arvalid}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_axi_valids", {27'd0, mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
